wb_regfile_hilo: RTL
====================

Name: wb_regfile_hilo

Overview:
- Write-back sink for the MEM/WB pipeline register: commits the wb_* GPR and HI/LO write requests into architectural state.
- Holds 32 x 32-bit general registers (r0 hardwired to zero) plus the HI/LO pair.
- Serves two combinational GPR read ports to ID and one HI/LO read port to EX, each with same-cycle write-through bypass.
- Keeps two free-running commit counters for debug and performance.

Parameters:
- REG_NUM, 32, number of GPRs; the address width is 5.
- CNT_W, 32, width of each commit counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low: 0 = reset asserted.
- wb_wd  input  5  GPR destination address from MEM/WB.
- wb_wreg  input  1  GPR write enable from MEM/WB.
- wb_wdata  input  32  GPR write data.
- wb_whilo  input  1  HI/LO write enable.
- wb_hi  input  32  HI write data.
- wb_lo  input  32  LO write data.
- re1  input  1  read-port-1 enable.
- raddr1  input  5  read-port-1 address.
- rdata1  output  32  read-port-1 data (combinational).
- re2  input  1  read-port-2 enable.
- raddr2  input  5  read-port-2 address.
- rdata2  output  32  read-port-2 data (combinational).
- hi_o  output  32  current HI (combinational, bypassed).
- lo_o  output  32  current LO (combinational, bypassed).
- gpr_commit_cnt  output  CNT_W  count of committed GPR writes.
- hilo_commit_cnt  output  CNT_W  count of committed HI/LO writes.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears all GPRs, HI, LO and both counters to 0 immediately.
  - While rst=0, rdata1, rdata2, hi_o and lo_o are forced to 0 and writes are ignored.
  - Reset deasserting mid-stream: the first edge after release is the first edge that may commit.
- GPR write:
  - On a rising edge with rst=1, wb_wreg=1 and wb_wd!=0: reg[wb_wd] <= wb_wdata.
  - Writes to wb_wd=0 are discarded; r0 always reads 0.
- GPR read, per port n (evaluated in this priority order):
  - ren=0 -> 0.
  - raddrn=0 -> 0.
  - wb_wreg=1 and wb_wd==raddrn -> wb_wdata (bypass).
  - Otherwise reg[raddrn].
  - Both ports may read the same address simultaneously; both see the same value.
- HI/LO:
  - On a rising edge with wb_whilo=1: HI <= wb_hi and LO <= wb_lo, always written together.
  - hi_o/lo_o = wb_whilo ? wb_hi/wb_lo : HI/LO (bypass).
- Bubble input (wb_wreg=0, wb_whilo=0, all other inputs 0): no state change and counters hold.
- Counters:
  - gpr_commit_cnt increments by 1 on each edge that actually writes a GPR, i.e. wb_wreg=1 and wb_wd!=0.
  - hilo_commit_cnt increments on each edge with wb_whilo=1.
  - Both wrap from 2^CNT_W-1 to 0 without flagging.
  - A GPR write and a HI/LO write on the same edge increment both counters.
- Latency:
  - A write is architecturally visible at the next edge.
  - Through bypass, readers see the write in the same cycle the request is presented; ID therefore needs no extra WB forwarding.
- No stall input: MEM/WB already converts stalls into bubbles.

Test Plan:
- Reset mid-write:
  - Stimulus: write r5=0xDEADBEEF, then pull rst=0 between clock edges.
  - Required: rdata1 (raddr1=5, re1=1) drops to 0 immediately; after release r5 reads 0 and gpr_commit_cnt=0.
- r0 protection:
  - Stimulus: wb_wreg=1, wb_wd=0, wb_wdata=0x12345678 for one edge.
  - Required: rdata1 at raddr1=0 reads 0 in that cycle and after; gpr_commit_cnt is unchanged.
- Bypass:
  - Stimulus: r7 holds 0x11; present wb_wreg=1, wb_wd=7, wb_wdata=0x22 with raddr1=raddr2=7.
  - Required: both ports read 0x22 before the edge; after the edge with wb_wreg=0, both still read 0x22.
- Read enable off:
  - Stimulus: r3=0xAA, re2=0, raddr2=3.
  - Required: rdata2=0; raising re2 gives 0xAA.
- HI/LO:
  - Stimulus: wb_whilo=1, wb_hi=0x1, wb_lo=0x2 for one edge, then a bubble.
  - Required: hi_o/lo_o read 1/2 during and after; hilo_commit_cnt=1.
  - Stimulus: a simultaneous GPR write to r9 on the same edge.
  - Required: both counters increment.
- Counter wrap:
  - Stimulus: with CNT_W=4, perform 17 GPR writes to r1.
  - Required: gpr_commit_cnt=1; r1 holds the last data value written.

Source files
------------

// File: rtl/wb_regfile_hilo_if.sv
// Write-back and read-port bundle between the MEM/WB and ID/EX stages
// and the architectural register file.
interface wb_regfile_hilo_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       wb_wd;
  logic             wb_wreg;
  logic [31:0]      wb_wdata;
  logic             wb_whilo;
  logic [31:0]      wb_hi;
  logic [31:0]      wb_lo;
  logic             re1;
  logic [4:0]       raddr1;
  logic [31:0]      rdata1;
  logic             re2;
  logic [4:0]       raddr2;
  logic [31:0]      rdata2;
  logic [31:0]      hi_o;
  logic [31:0]      lo_o;
  logic [CNT_W-1:0] gpr_commit_cnt;
  logic [CNT_W-1:0] hilo_commit_cnt;

  modport master (
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, gpr_commit_cnt, hilo_commit_cnt
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, gpr_commit_cnt, hilo_commit_cnt
  );
endinterface

// File: rtl/wb_regfile_hilo.sv
// Architectural GPR file plus HI/LO pair, written from MEM/WB, with
// same-cycle write-through bypass on all read ports and commit counters.
module wb_regfile_hilo #(
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 32
) (
  input logic              clk,
  input logic              rst,
  wb_regfile_hilo_if.slave bus
);
  localparam int AW = 5;

  logic [31:0]      regs [REG_NUM];
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [CNT_W-1:0] gpr_cnt;
  logic [CNT_W-1:0] hilo_cnt;
  logic             gpr_we;

  // r0 is never written, so a write to address 0 is not a commit either.
  assign gpr_we = bus.wb_wreg && (bus.wb_wd != '0);

  // NOTE: the GPR array sits on the async reset because architectural
  // state must read zero right after reset; this forces flops, not a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (gpr_we) begin
      regs[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      gpr_cnt  <= '0;
      hilo_cnt <= '0;
    end else begin
      if (bus.wb_whilo) begin
        hi_q     <= bus.wb_hi;
        lo_q     <= bus.wb_lo;
        hilo_cnt <= hilo_cnt + CNT_W'(1);
      end
      if (gpr_we) gpr_cnt <= gpr_cnt + CNT_W'(1);
    end
  end

  function automatic logic [31:0] read_port(input logic re, input logic [AW-1:0] addr);
    if (!re || addr == '0)                    return '0;
    else if (bus.wb_wreg && bus.wb_wd == addr) return bus.wb_wdata;
    else                                      return regs[addr];
  endfunction

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    bus.hi_o   = '0;
    bus.lo_o   = '0;
    if (rst) begin
      bus.rdata1 = read_port(bus.re1, bus.raddr1);
      bus.rdata2 = read_port(bus.re2, bus.raddr2);
      bus.hi_o   = bus.wb_whilo ? bus.wb_hi : hi_q;
      bus.lo_o   = bus.wb_whilo ? bus.wb_lo : lo_q;
    end
  end

  assign bus.gpr_commit_cnt  = gpr_cnt;
  assign bus.hilo_commit_cnt = hilo_cnt;
endmodule
